round_controller: RTL and testbench

//  Match/round sequencer sitting directly downstream of health_status.
//  - Consumes both players' health values.
//  - Runs countdown -> fight -> KO/timeout -> next round, keeps round scores and declares the match winner.
//  - Drives freeze to the player FSMs and a round-restart pulse back into health_status.

---
 rtl/round_controller_pkg.sv | 37 +++
 rtl/round_controller_sec_ticker.sv | 39 +++
 rtl/round_controller.sv | 206 ++++++++++++++++++++
 tb/tb_round_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_controller_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared types and constants for the match/round sequencer.
//   - state_t  : round_controller FSM states, encoded as seen on the state port
//   - winner_t : winner codes driven on the winner port
//   - MAX_HEALTH and helpers for KO decoding and saturating score counters
// ---------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_COUNTDOWN  = 3'd1,
      S_FIGHT      = 3'd2,
      S_KO         = 3'd3,
      S_MATCH_OVER = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      W_NONE = 2'd0,
      W_P1   = 2'd1,
      W_P2   = 2'd2,
      W_DRAW = 2'd3
   } winner_t;

   localparam logic [2:0] MAX_HEALTH = 3'd3;

   // A health counter that wrapped below zero shows up as a value above
   // MAX_HEALTH, so it counts as a knockout just like zero.
   function automatic logic is_ko(input logic [2:0] health);
      return (health == 3'd0) || (health > MAX_HEALTH);
   endfunction

   function automatic logic [1:0] bump_score(input logic [1:0] score);
      return (score == 2'd3) ? score : score + 2'd1;
   endfunction

endpackage

// File: rtl/round_controller_sec_ticker.sv
// ---------------------------------------------------------------------------
// sec_ticker
//   One-second divider for the round sequencer.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-low reset
//     clr   in  synchronous clear; restarts the current second
//     tick  out single-cycle pulse once every TICKS_PER_SEC cycles
//   After a clear the first tick lands TICKS_PER_SEC cycles later.
// ---------------------------------------------------------------------------
module sec_ticker #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   // tick depends only on the counter, so a clear derived from next-state
   // logic (which itself uses tick) does not form a combinational loop.
   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/round_controller.sv
// ---------------------------------------------------------------------------
// round_controller
//   Match/round sequencer downstream of health_status: countdown, fight,
//   KO/timeout, round scoring and match winner.
//   Ports:
//     clk             in   system clock
//     rst             in   synchronous active-low reset
//     start           in   level start button, rising edge detected here
//     player1_health  in   3-bit health, 0 or >3 means KO
//     player2_health  in   3-bit health, 0 or >3 means KO
//     state           out  IDLE=0 COUNTDOWN=1 FIGHT=2 KO=3 MATCH_OVER=4
//     freeze          out  1 except in FIGHT
//     round_rst       out  1-cycle pulse on each COUNTDOWN entry
//     countdown       out  seconds left in COUNTDOWN, else 0
//     timer           out  fight seconds remaining
//     p1_wins         out  rounds won by P1 (saturates at 3)
//     p2_wins         out  rounds won by P2 (saturates at 3)
//     round_num       out  current round, 1-based, 0 in IDLE
//     winner          out  0 none, 1 P1, 2 P2, 3 draw; set on MATCH_OVER entry
// ---------------------------------------------------------------------------
module round_controller
   import game_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned ROUND_SECS    = 60,
   parameter int unsigned COUNT_SECS    = 3,
   parameter int unsigned KO_SECS       = 2,
   parameter int unsigned ROUNDS_TO_WIN = 2,
   parameter int unsigned MAX_ROUNDS    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] player1_health,
   input  logic [2:0] player2_health,
   output logic [2:0] state,
   output logic       freeze,
   output logic       round_rst,
   output logic [1:0] countdown,
   output logic [6:0] timer,
   output logic [1:0] p1_wins,
   output logic [1:0] p2_wins,
   output logic [2:0] round_num,
   output logic [1:0] winner
);

   localparam logic [6:0] TIMER_INIT  = 7'(ROUND_SECS);
   localparam logic [1:0] COUNT_INIT  = 2'(COUNT_SECS);
   localparam logic [6:0] HOLD_LAST   = 7'(KO_SECS - 1);
   localparam logic [1:0] WIN_TARGET  = 2'(ROUNDS_TO_WIN);
   localparam logic [2:0] ROUND_LIMIT = 3'(MAX_ROUNDS);

   state_t     state_q;
   state_t     state_d;
   winner_t    winner_q;
   logic       start_q;
   logic       start_rise;
   logic       sec_tick;
   logic       state_chg;
   logic       p1_ko;
   logic       p2_ko;
   logic       p1_scores;
   logic       p2_scores;
   logic       match_done;
   logic [6:0] hold_cnt;

   assign state      = state_q;
   assign winner     = winner_q;
   assign freeze     = (state_q != S_FIGHT);
   assign start_rise = start & ~start_q;
   assign p1_ko      = is_ko(player1_health);
   assign p2_ko      = is_ko(player2_health);
   assign state_chg  = (state_d != state_q);
   assign match_done = (p1_wins == WIN_TARGET) || (p2_wins == WIN_TARGET) ||
                       (round_num == ROUND_LIMIT);

   // Divider restarts on every state change so each state gets a full
   // second before its first tick.
   sec_ticker #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_sec_ticker (
      .clk (clk),
      .rst (rst),
      .clr (state_chg),
      .tick(sec_tick)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_MATCH_OVER: begin
            if (start_rise) state_d = S_COUNTDOWN;
         end
         S_COUNTDOWN: begin
            if (sec_tick && (countdown == 2'd1)) state_d = S_FIGHT;
         end
         S_FIGHT: begin
            if (p1_ko || p2_ko || (sec_tick && (timer == 7'd1))) state_d = S_KO;
         end
         S_KO: begin
            if (sec_tick && (hold_cnt == HOLD_LAST)) begin
               state_d = match_done ? S_MATCH_OVER : S_COUNTDOWN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Round result for the FIGHT->KO transition. Any KO decides the round
   // before the timeout comparison is considered.
   // ---------------------------------------------------------------------
   always_comb begin
      p1_scores = 1'b0;
      p2_scores = 1'b0;
      if (p1_ko && p2_ko) begin
         p1_scores = 1'b0;
      end else if (p1_ko) begin
         p2_scores = 1'b1;
      end else if (p2_ko) begin
         p1_scores = 1'b1;
      end else if (player1_health > player2_health) begin
         p1_scores = 1'b1;
      end else if (player2_health > player1_health) begin
         p2_scores = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Timers, scores, round counter and start edge register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         start_q   <= 1'b0;
         round_rst <= 1'b0;
         countdown <= '0;
         timer     <= TIMER_INIT;
         p1_wins   <= '0;
         p2_wins   <= '0;
         round_num <= '0;
         winner_q  <= W_NONE;
         hold_cnt  <= '0;
      end else begin
         start_q   <= start;
         round_rst <= 1'b0;
         case (state_q)
            S_IDLE, S_MATCH_OVER: begin
               if (state_d == S_COUNTDOWN) begin
                  round_num <= 3'd1;
                  p1_wins   <= '0;
                  p2_wins   <= '0;
                  winner_q  <= W_NONE;
                  round_rst <= 1'b1;
                  countdown <= COUNT_INIT;
                  timer     <= TIMER_INIT;
               end
            end
            S_COUNTDOWN: begin
               if (sec_tick) countdown <= countdown - 2'd1;
            end
            S_FIGHT: begin
               if (sec_tick) timer <= timer - 7'd1;
               if (state_d == S_KO) begin
                  hold_cnt <= '0;
                  if (p1_scores) p1_wins <= bump_score(p1_wins);
                  if (p2_scores) p2_wins <= bump_score(p2_wins);
               end
            end
            S_KO: begin
               if (sec_tick) hold_cnt <= hold_cnt + 7'd1;
               if (state_d == S_MATCH_OVER) begin
                  if (p1_wins > p2_wins) begin
                     winner_q <= W_P1;
                  end else if (p2_wins > p1_wins) begin
                     winner_q <= W_P2;
                  end else begin
                     winner_q <= W_DRAW;
                  end
               end else if (state_d == S_COUNTDOWN) begin
                  round_num <= round_num + 3'd1;
                  round_rst <= 1'b1;
                  countdown <= COUNT_INIT;
                  timer     <= TIMER_INIT;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// ---------------------------------------------------------------------------
// tb_round_controller
//   Randomized match stimulus with a scoreboard. Each round's outcome is
//   worked out from the game rules (KO decoding, timeout comparison, score
//   targets) and pushed as expected state-entry events; a monitor pops an
//   event on every observed state change and checks all outputs each cycle.
// ---------------------------------------------------------------------------
module tb_round_controller;

   localparam int TPS = 4;
   localparam int RS  = 5;
   localparam int CS  = 3;
   localparam int KOS = 2;
   localparam int R2W = 2;
   localparam int MR  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] h1 = 3'd3;
   logic [2:0] h2 = 3'd3;
   logic [2:0] state;
   logic       freeze;
   logic       round_rst;
   logic [1:0] countdown;
   logic [6:0] timer;
   logic [1:0] p1_wins;
   logic [1:0] p2_wins;
   logic [2:0] round_num;
   logic [1:0] winner;

   always #5 clk = ~clk;

   round_controller #(
      .TICKS_PER_SEC(TPS),
      .ROUND_SECS   (RS),
      .COUNT_SECS   (CS),
      .KO_SECS      (KOS),
      .ROUNDS_TO_WIN(R2W),
      .MAX_ROUNDS   (MR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .player1_health(h1),
      .player2_health(h2),
      .state         (state),
      .freeze        (freeze),
      .round_rst     (round_rst),
      .countdown     (countdown),
      .timer         (timer),
      .p1_wins       (p1_wins),
      .p2_wins       (p2_wins),
      .round_num     (round_num),
      .winner        (winner)
   );

   logic [22:0] act_vec;
   assign act_vec = {state, freeze, round_rst, countdown, timer,
                     p1_wins, p2_wins, round_num, winner};

   localparam logic [22:0] RESET_VEC = {3'd0, 1'b1, 1'b0, 2'd0, 7'(RS),
                                        2'd0, 2'd0, 3'd0, 2'd0};

   // Expected state-entry event; dwell = cycles since previous entry (-1 = any)
   typedef struct {
      logic [2:0] st;
      logic [2:0] rnd;
      logic [1:0] w1;
      logic [1:0] w2;
      logic [1:0] win;
      logic [6:0] tmr;
      int         dwell;
   } ev_t;

   ev_t  q[$];
   ev_t  cur;
   ev_t  m_e;
   bit   m_evt;
   bit   mon_en = 1'b0;
   logic [2:0] prev_st = 3'd0;
   int   dwell = 0;
   int   checks = 0;
   int   passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic ev_t mk(input int st, input int rnd, input int w1, input int w2,
                              input int win, input int tmr, input int dw);
      ev_t e;
      e.st    = 3'(st);
      e.rnd   = 3'(rnd);
      e.w1    = 2'(w1);
      e.w2    = 2'(w2);
      e.win   = 2'(win);
      e.tmr   = 7'(tmr);
      e.dwell = dw;
      return e;
   endfunction

   // Outputs expected dw cycles after entering the state described by e
   function automatic logic [22:0] exp_vec(input ev_t e, input int dw, input bit evt);
      int cd;
      int tm;
      bit fr;
      bit rr;
      cd = (e.st == 3'd1) ? CS - dw / TPS : 0;
      tm = (e.st == 3'd2) ? RS - dw / TPS : int'(e.tmr);
      fr = (e.st != 3'd2);
      rr = evt && (e.st == 3'd1);
      return {e.st, fr, rr, 2'(cd), 7'(tm), e.w1, e.w2, e.rnd, e.win};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!mon_en) begin
         cur     = mk(0, 0, 0, 0, 0, RS, -1);
         prev_st = 3'd0;
         dwell   = 0;
      end else begin
         dwell++;
         m_evt = 1'b0;
         if (state !== prev_st) begin
            m_evt = 1'b1;
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_transition: got state %0d expected state %0d at %0t",
                        state, prev_st, $time);
            end else begin
               m_e = q.pop_front();
               check("event_state", 32'(state), 32'(m_e.st));
               if (m_e.dwell >= 0) check("event_dwell", 32'(dwell), 32'(m_e.dwell));
               cur = m_e;
            end
            dwell   = 0;
            prev_st = state;
         end
         check("outputs", 32'(act_vec), 32'(exp_vec(cur, dwell, m_evt)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_state(input logic [2:0] s, input int budget, input string what);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (state !== s) begin
         checks++;
         $display("FAIL %s: got state %0d expected state %0d (timeout)", what, state, s);
      end
   endtask

   function automatic logic [2:0] ko_val();
      int v;
      v = $urandom_range(3, 7);
      return (v == 3) ? 3'd0 : 3'(v);
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: random rounds, 1: draws only, 2: P1 wins, 3: timeouts only
   task automatic run_match(input int mode);
      int r = 1;
      int w1 = 0;
      int w2 = 0;
      bit done = 1'b0;
      int kind;
      int d;
      int res;
      int tmr_at;
      int dw;
      int win;
      int n;
      logic [2:0] a1, a2, f1, f2;
      bit k1, k2;
      h1 = 3'd3;
      h2 = 3'd3;
      q.push_back(mk(1, 1, 0, 0, 0, RS, -1));
      q.push_back(mk(2, 1, 0, 0, 0, RS, CS * TPS));
      pulse_start();
      while (!done) begin
         wait_state(3'd2, 40, "reach_fight");
         if (state !== 3'd2) begin
            q.delete();
            return;
         end
         a1 = 3'($urandom_range(1, 3));
         a2 = 3'($urandom_range(1, 3));
         d  = $urandom_range(0, 18);
         case (mode)
            1:       kind = $urandom_range(2, 3);
            2:       kind = ($urandom_range(0, 1) == 0) ? 1 : 3;
            3:       kind = 3;
            default: kind = $urandom_range(0, 3);
         endcase
         if (mode == 1 && kind == 3) a2 = a1;
         if (mode == 2 && kind == 3) begin
            a1 = 3'd3;
            a2 = 3'($urandom_range(1, 2));
         end
         f1 = a1;
         f2 = a2;
         if (kind == 0 || kind == 2) f1 = ko_val();
         if (kind == 1 || kind == 2) f2 = (mode == 2) ? 3'd7 : ko_val();

         // Round outcome from the rules
         k1 = (f1 == 3'd0) || (f1 > 3'd3);
         k2 = (f2 == 3'd0) || (f2 > 3'd3);
         if (k1 && k2)      res = 0;
         else if (k1)       res = 2;
         else if (k2)       res = 1;
         else if (f1 > f2)  res = 1;
         else if (f2 > f1)  res = 2;
         else               res = 0;
         if (res == 1 && w1 < 3) w1++;
         if (res == 2 && w2 < 3) w2++;
         tmr_at = (kind == 3) ? 0 : RS - (d + 1) / TPS;
         dw     = (kind == 3) ? RS * TPS : d + 1;
         q.push_back(mk(3, r, w1, w2, 0, tmr_at, dw));
         if (w1 == R2W || w2 == R2W || r == MR) begin
            win = (w1 > w2) ? 1 : (w2 > w1) ? 2 : 3;
            q.push_back(mk(4, r, w1, w2, win, tmr_at, KOS * TPS));
            done = 1'b1;
         end else begin
            r++;
            q.push_back(mk(1, r, w1, w2, 0, RS, KOS * TPS));
            q.push_back(mk(2, r, w1, w2, 0, RS, CS * TPS));
         end

         // Drive the round; a start edge inside FIGHT must change nothing
         start = 1'($urandom_range(0, 1));
         h1 = a1;
         h2 = a2;
         if (kind != 3) begin
            repeat (d) @(negedge clk);
            h1 = f1;
            h2 = f2;
         end
         wait_state(3'd3, 25, "reach_ko");
         start = 1'b0;
         // Health noise outside FIGHT must be ignored
         h1 = 3'($urandom_range(0, 7));
         h2 = 3'($urandom_range(0, 7));
         n = 0;
         while (state === 3'd3 && n < 20) begin
            @(negedge clk);
            n++;
         end
         h1 = 3'd3;
         h2 = 3'd3;
      end
      wait_state(3'd4, 5, "reach_match_over");
      repeat (3) @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(act_vec), 32'(RESET_VEC));
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      run_match(0);
      run_match(2);
      run_match(1);
      run_match(3);
      run_match(0);
      run_match(2);

      // Reset mid-fight once the timer shows 3
      q.push_back(mk(1, 1, 0, 0, 0, RS, -1));
      q.push_back(mk(2, 1, 0, 0, 0, RS, CS * TPS));
      pulse_start();
      wait_state(3'd2, 40, "reach_fight_before_reset");
      repeat (2 * TPS) @(negedge clk);
      check("timer_before_reset", 32'(timer), 32'd3);
      mon_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("mid_fight_reset", 32'(act_vec), 32'(RESET_VEC));
      check("queue_empty_at_reset", 32'(q.size()), 32'd0);
      q.delete();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      run_match(0);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
